aes_round_ctrl: RTL

//  Sequencer for the AES-128 round datapath and the key scheduler (ks_*).
//  - Runs a key expansion once, then steps rounds 0..NR for each accepted block.
//  - Presents the matching round-key index and per-round datapath strobes.
//  - Uses valid/ready handshakes upstream and downstream.
//  - Sits between the top-level I/O and both the key scheduler and the round datapath.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_round_ctrl_if.sv | 26 ++
 rtl/aes_ks_watchdog.sv | 36 +++
 rtl/aes_round_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES controller definitions: round count, key-select width and the
// controller state encoding used by the round sequencer and key scheduler.
package aes_pkg;

  localparam int AES_NR       = 10;
  localparam int AES_KS_SEL_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    KRST,
    KEN,
    KWAIT,
    ROUND,
    DONE,
    ERR
  } aes_rc_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-level handshake bundle for the AES round controller.
// Optional macro AES_RC_DECRYPT_EN adds the per-block dec flag.
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high. A source holding valid keeps its payload stable
// until that edge; ready may depend on state but never on the same-cycle
// valid of the other side.
interface aes_round_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
`ifdef AES_RC_DECRYPT_EN
  logic dec;

  modport master (output in_valid, output out_ready, output dec,
                  input in_ready, input out_valid);
  modport slave  (input in_valid, input out_ready, input dec,
                  output in_ready, output out_valid);
`else
  modport master (output in_valid, output out_ready,
                  input in_ready, input out_valid);
  modport slave  (input in_valid, input out_ready,
                  output in_ready, output out_valid);
`endif
endinterface

// File: rtl/aes_ks_watchdog.sv
// Key-scheduler timeout counter. After clear, cnt_q holds the number of clock
// edges elapsed since the clearing cycle; expire flags that the coming edge is
// the TIMEOUT-th one, so the owner can leave its wait state exactly then.
module aes_ks_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: restart at one edge, otherwise count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CW'(1);
    end else if (count && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire = count && ((int'(cnt_q) + 1) == TIMEOUT);

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: expands the key once (or after key_reload), then
// steps rounds 0..NR per accepted block and holds the result until taken.
// Optional macro AES_RC_DECRYPT_EN adds a per-block dec flag that reverses
// the round-key select order.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR         = AES_NR,
  parameter int KS_TIMEOUT = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  aes_round_ctrl_if.slave         io,
  input  logic                    key_reload,
  output logic                    ks_rst,
  output logic                    ks_en,
  input  logic                    ks_ry,
  output logic [AES_KS_SEL_W-1:0] ks_sel,
  output logic                    rnd_load,
  output logic                    rnd_full,
  output logic                    rnd_last,
  output logic                    busy,
  output logic                    err,
  output aes_rc_state_e           dbg_state
);

  if (NR > 15 || NR < 1) begin : g_nr_check
    $error("aes_round_ctrl: NR must be within 1..15");
  end

  localparam logic [AES_KS_SEL_W-1:0] NR_L = AES_KS_SEL_W'(NR);

  aes_rc_state_e           state_q, state_d;
  logic [AES_KS_SEL_W-1:0] rnd_q, rnd_d;
  logic                    key_ok_q, key_ok_d;
  logic                    reload_pend_q, reload_pend_d;
  logic                    in_ready_c, out_valid_c;
  logic                    wd_clear, wd_count, wd_expire;
  logic [AES_KS_SEL_W-1:0] sel_c;

`ifdef AES_RC_DECRYPT_EN
  logic dec_q, dec_d;
  assign sel_c = dec_q ? (NR_L - rnd_q) : rnd_q;
`else
  assign sel_c = rnd_q;
`endif

  aes_ks_watchdog #(.TIMEOUT(KS_TIMEOUT)) u_wd (
    .clk    (Clk),
    .rst    (Rst),
    .clear  (wd_clear),
    .count  (wd_count),
    .expire (wd_expire)
  );

  // Next-state and Moore outputs of the sequencer.
  always_comb begin
    state_d       = state_q;
    rnd_d         = rnd_q;
    key_ok_d      = key_ok_q;
    reload_pend_d = reload_pend_q | key_reload;
`ifdef AES_RC_DECRYPT_EN
    dec_d         = dec_q;
`endif
    in_ready_c    = 1'b0;
    out_valid_c   = 1'b0;
    ks_rst        = 1'b0;
    ks_en         = 1'b0;
    ks_sel        = '0;
    rnd_load      = 1'b0;
    rnd_full      = 1'b0;
    rnd_last      = 1'b0;
    err           = 1'b0;
    wd_clear      = 1'b0;
    wd_count      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c = key_ok_q & ~reload_pend_q;
        if (reload_pend_q || (io.in_valid && !key_ok_q)) begin
          state_d = KRST;
        end else if (io.in_valid && in_ready_c) begin
          state_d = ROUND;
          rnd_d   = '0;
`ifdef AES_RC_DECRYPT_EN
          dec_d   = io.dec;
`endif
        end
      end
      KRST: begin
        ks_rst   = 1'b1;
        key_ok_d = 1'b0;
        state_d  = KEN;
      end
      KEN: begin
        ks_en    = 1'b1;
        wd_clear = 1'b1;
        state_d  = KWAIT;
      end
      KWAIT: begin
        wd_count = 1'b1;
        if (ks_ry) begin
          key_ok_d      = 1'b1;
          reload_pend_d = key_reload;
          state_d       = IDLE;
        end else if (wd_expire) begin
          state_d = ERR;
        end
      end
      ROUND: begin
        ks_sel   = sel_c;
        rnd_load = (rnd_q == '0);
        rnd_last = (rnd_q == NR_L);
        rnd_full = !rnd_load && !rnd_last;
        if (rnd_q == NR_L) state_d = DONE;
        else               rnd_d   = rnd_q + 1'b1;
      end
      DONE: begin
        out_valid_c = 1'b1;
        ks_sel      = sel_c;
        if (io.out_ready) state_d = IDLE;
      end
      ERR: begin
        err = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_c;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

  // State registers; Rst overrides everything, including key_reload.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      rnd_q         <= '0;
      key_ok_q      <= 1'b0;
      reload_pend_q <= 1'b0;
`ifdef AES_RC_DECRYPT_EN
      dec_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rnd_q         <= rnd_d;
      key_ok_q      <= key_ok_d;
      reload_pend_q <= reload_pend_d;
`ifdef AES_RC_DECRYPT_EN
      dec_q         <= dec_d;
`endif
    end
  end

endmodule
